// File: rtl/flexsoc_rst_seq.sv
// flexsoc_rst_seq: reset sequencer for flexsoc FPGA tops.
// It merges the pushbutton, PLL lock and software reset sources into one
// trigger. It then releases NUM_RST active-low domain resets in index order,
// with a programmable stagger between releases. A sticky register records
// which sources caused a reset.
module flexsoc_rst_seq #(
  parameter int NUM_LOCK = 2,
  parameter int NUM_RST  = 2,
  parameter int STRETCH  = 16,
  parameter int STAGGER  = 4,
  parameter int DEBOUNCE = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                BTN_RESETn,
  input  logic [NUM_LOCK-1:0] LOCKED,
  input  logic                SW_RST,
  input  logic                CAUSE_CLR,
  output logic [NUM_RST-1:0]  RSTn_OUT,
  output logic                READY,
  output logic [3:0]          CAUSE
);

  localparam int MAX_SS  = (STRETCH > STAGGER) ? STRETCH : STAGGER;
  localparam int MAX_CNT = (MAX_SS > DEBOUNCE) ? MAX_SS : DEBOUNCE;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam int IW      = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;

  localparam logic [CW-1:0] STRETCH_LAST  = CW'(STRETCH - 1);
  localparam logic [CW-1:0] STAGGER_LAST  = CW'(STAGGER - 1);
  localparam logic [CW-1:0] DEBOUNCE_LAST = CW'(DEBOUNCE - 1);
  localparam logic [IW-1:0] IDX_LAST_STEP = IW'((NUM_RST > 1) ? NUM_RST - 2 : 0);

  typedef enum logic [1:0] {
    S_HOLD,
    S_STRETCH,
    S_RELEASE,
    S_RUN
  } state_t;

  logic                btn_meta;
  logic                btn_sync;
  logic [NUM_LOCK-1:0] lock_meta;
  logic [NUM_LOCK-1:0] lock_sync;
  logic                all_locked;
  logic                lock_seen;
  logic                lock_lost;
  logic                btn_down;
  logic                pressed;
  logic [CW-1:0]       deb_cnt;
  logic                trigger;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [NUM_RST-1:0]  rstn_q, rstn_d;
  logic                ready_q, ready_d;
  logic [3:0]          cause_q, cause_d;
  logic [3:0]          cause_set;

  // Two-flop synchronisers for the asynchronous button and lock inputs.
  // The button resets to "released" and the locks reset to "unlocked".
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      btn_meta  <= 1'b1;
      btn_sync  <= 1'b1;
      lock_meta <= '0;
      lock_sync <= '0;
    end else begin
      btn_meta  <= BTN_RESETn;
      btn_sync  <= btn_meta;
      lock_meta <= LOCKED;
      lock_sync <= lock_meta;
    end
  end

  assign all_locked = &lock_sync;
  assign btn_down   = ~btn_sync;

  // Debounce: 'pressed' changes only after DEBOUNCE consecutive disagreeing samples.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pressed <= 1'b0;
      deb_cnt <= '0;
    end else if (btn_down != pressed) begin
      if (deb_cnt == DEBOUNCE_LAST) begin
        pressed <= btn_down;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end else begin
      deb_cnt <= '0;
    end
  end

  // Remembers that the PLLs have locked at least once. The wait for the first
  // lock after power-on is then not recorded as a lock-loss cause.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lock_seen <= 1'b0;
    end else if (all_locked) begin
      lock_seen <= 1'b1;
    end
  end

  assign lock_lost = lock_seen & ~all_locked;
  assign trigger   = pressed | ~all_locked | SW_RST;

  // State, counters, staged outputs and cause register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      rstn_q  <= '0;
      ready_q <= 1'b0;
      cause_q <= 4'b0001;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rstn_q  <= rstn_d;
      ready_q <= ready_d;
      cause_q <= cause_d;
    end
  end

  // Next-state logic. Any trigger forces HOLD and drops every output on the
  // same edge, so the release order can never be left half done.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rstn_d  = rstn_q;
    ready_d = ready_q;
    if (trigger) begin
      state_d = S_HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      rstn_d  = '0;
      ready_d = 1'b0;
    end else begin
      case (state_q)
        S_HOLD: begin
          state_d = S_STRETCH;
          cnt_d   = '0;
        end
        S_STRETCH: begin
          if (cnt_q == STRETCH_LAST) begin
            cnt_d     = '0;
            idx_d     = '0;
            rstn_d[0] = 1'b1;
            if (NUM_RST == 1) begin
              state_d = S_RUN;
              ready_d = 1'b1;
            end else begin
              state_d = S_RELEASE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_RELEASE: begin
          if (cnt_q == STAGGER_LAST) begin
            cnt_d         = '0;
            idx_d         = idx_q + 1'b1;
            rstn_d[idx_d] = 1'b1;
            if (idx_q == IDX_LAST_STEP) begin
              state_d = S_RUN;
              ready_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_RUN: begin
          state_d = S_RUN;
        end
        default: begin
          state_d = S_HOLD;
          rstn_d  = '0;
          ready_d = 1'b0;
        end
      endcase
    end
  end

  // Cause bits latch whenever HOLD is entered or held. A set on a bit wins
  // over a clear of that bit on the same edge.
  always_comb begin
    cause_set = '0;
    if (state_d == S_HOLD) begin
      cause_set = {SW_RST, lock_lost, pressed, 1'b0};
    end
    cause_d = (CAUSE_CLR ? 4'b0000 : cause_q) | cause_set;
  end

  assign RSTn_OUT = rstn_q;
  assign READY    = ready_q;
  assign CAUSE    = cause_q;

endmodule
